// File: rtl/sdram_arbiter.sv
// Two-client round-robin arbiter in front of an SDRAM controller user port.
// Serialises one transaction at a time, routes read data back to its owner and aborts stuck commands.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT = 1023,
  parameter logic        FIRST   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_req,
  input  logic        c1_req,
  input  logic        c0_rw,
  input  logic        c1_rw,
  input  logic [22:0] c0_addr,
  input  logic [22:0] c1_addr,
  input  logic [31:0] c0_wdata,
  input  logic [31:0] c1_wdata,
  output logic        c0_ack,
  output logic        c1_ack,
  output logic [31:0] c0_rdata,
  output logic [31:0] c1_rdata,
  output logic        c0_rvalid,
  output logic        c1_rvalid,
  output logic [22:0] addr,
  output logic        rw,
  output logic [31:0] data_in,
  output logic        in_valid,
  input  logic [31:0] data_out,
  input  logic        busy,
  input  logic        out_valid,
  output logic        owner,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  localparam logic [9:0] TIMEOUT_L = 10'(TIMEOUT);

  state_t      state_q, state_d;
  logic        c0_ack_q, c0_ack_d;
  logic        c1_ack_q, c1_ack_d;
  logic [31:0] c0_rdata_q, c0_rdata_d;
  logic [31:0] c1_rdata_q, c1_rdata_d;
  logic        c0_rvalid_q, c0_rvalid_d;
  logic        c1_rvalid_q, c1_rvalid_d;
  logic [22:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] data_in_q, data_in_d;
  logic        in_valid_q, in_valid_d;
  logic        owner_q, owner_d;
  logic        timeout_q, timeout_d;
  logic        last_q, last_d;
  logic [9:0]  cnt_q, cnt_d;

  logic        in_wait_s;
  logic        start_s;
  logic        grant_s;
  logic        rd_done_s;
  logic        wr_done_s;
  logic        expire_s;

  // Arbitration and completion decode shared by next-state and output logic
  always_comb begin
    in_wait_s = (state_q == WAIT_START) || (state_q == WAIT_DONE);
    start_s   = (state_q == IDLE) && !busy && (c0_req || c1_req);
    // Under contention the client that was not served last wins
    if (c0_req && c1_req) begin
      grant_s = ~last_q;
    end else begin
      grant_s = c1_req;
    end
    rd_done_s = in_wait_s && !rw_q && out_valid;
    wr_done_s = (state_q == WAIT_DONE) && rw_q && !busy;
    expire_s  = in_wait_s && ((cnt_q + 10'd1) == TIMEOUT_L);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (rd_done_s || expire_s) begin
          state_d = IDLE;
        end else if (busy) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_START;
        end
      end
      WAIT_DONE: begin
        if (rd_done_s || wr_done_s || expire_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM output logic: next values of every registered output
  always_comb begin
    c0_ack_d    = 1'b0;
    c1_ack_d    = 1'b0;
    c0_rvalid_d = 1'b0;
    c1_rvalid_d = 1'b0;
    in_valid_d  = 1'b0;
    c0_rdata_d  = c0_rdata_q;
    c1_rdata_d  = c1_rdata_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    data_in_d   = data_in_q;
    owner_d     = owner_q;
    timeout_d   = timeout_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          owner_d    = grant_s;
          in_valid_d = 1'b1;
          if (grant_s) begin
            addr_d    = c1_addr;
            rw_d      = c1_rw;
            data_in_d = c1_wdata;
            c1_ack_d  = 1'b1;
          end else begin
            addr_d    = c0_addr;
            rw_d      = c0_rw;
            data_in_d = c0_wdata;
            c0_ack_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ISSUE: begin
        cnt_d = 10'd0;
      end
      WAIT_START, WAIT_DONE: begin
        cnt_d = cnt_q + 10'd1;
        // A completion seen on the same cycle as expiry still counts as a completion
        if (rd_done_s) begin
          last_d = owner_q;
          if (owner_q) begin
            c1_rdata_d  = data_out;
            c1_rvalid_d = 1'b1;
          end else begin
            c0_rdata_d  = data_out;
            c0_rvalid_d = 1'b1;
          end
        end else if (wr_done_s) begin
          last_d = owner_q;
        end else if (expire_s) begin
          last_d    = owner_q;
          timeout_d = 1'b1;
        end else begin
          last_d = last_q;
        end
      end
      default: begin
        cnt_d = 10'd0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c0_ack_q    <= 1'b0;
      c1_ack_q    <= 1'b0;
      c0_rdata_q  <= 32'd0;
      c1_rdata_q  <= 32'd0;
      c0_rvalid_q <= 1'b0;
      c1_rvalid_q <= 1'b0;
      addr_q      <= 23'd0;
      rw_q        <= 1'b0;
      data_in_q   <= 32'd0;
      in_valid_q  <= 1'b0;
      owner_q     <= FIRST;
      timeout_q   <= 1'b0;
      last_q      <= ~FIRST;
      cnt_q       <= 10'd0;
    end else begin
      c0_ack_q    <= c0_ack_d;
      c1_ack_q    <= c1_ack_d;
      c0_rdata_q  <= c0_rdata_d;
      c1_rdata_q  <= c1_rdata_d;
      c0_rvalid_q <= c0_rvalid_d;
      c1_rvalid_q <= c1_rvalid_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      data_in_q   <= data_in_d;
      in_valid_q  <= in_valid_d;
      owner_q     <= owner_d;
      timeout_q   <= timeout_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign c0_ack    = c0_ack_q;
  assign c1_ack    = c1_ack_q;
  assign c0_rdata  = c0_rdata_q;
  assign c1_rdata  = c1_rdata_q;
  assign c0_rvalid = c0_rvalid_q;
  assign c1_rvalid = c1_rvalid_q;
  assign addr      = addr_q;
  assign rw        = rw_q;
  assign data_in   = data_in_q;
  assign in_valid  = in_valid_q;
  assign owner     = owner_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; the bench drives the controller side by hand.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c0_req = 1'b0, c1_req = 1'b0;
  logic        c0_rw = 1'b0, c1_rw = 1'b0;
  logic [22:0] c0_addr = 23'd0, c1_addr = 23'd0;
  logic [31:0] c0_wdata = 32'd0, c1_wdata = 32'd0;
  logic        c0_ack, c1_ack;
  logic [31:0] c0_rdata, c1_rdata;
  logic        c0_rvalid, c1_rvalid;
  logic [22:0] addr;
  logic        rw;
  logic [31:0] data_in;
  logic        in_valid;
  logic [31:0] data_out = 32'd0;
  logic        busy = 1'b0;
  logic        out_valid = 1'b0;
  logic        owner;
  logic        timeout;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int rv0_cnt = 0;
  int rv1_cnt = 0;

  sdram_arbiter #(.TIMEOUT(16), .FIRST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c1_req(c1_req), .c0_rw(c0_rw), .c1_rw(c1_rw),
    .c0_addr(c0_addr), .c1_addr(c1_addr), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_ack(c0_ack), .c1_ack(c1_ack), .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
    .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
    .addr(addr), .rw(rw), .data_in(data_in), .in_valid(in_valid),
    .data_out(data_out), .busy(busy), .out_valid(out_valid),
    .owner(owner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Count read-data pulses per client, sampled on the inactive edge
  always @(negedge clk) begin
    if (c0_rvalid) rv0_cnt++;
    if (c1_rvalid) rv1_cnt++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller model: called in the ISSUE cycle, finishes with the arbiter back in IDLE
  task automatic serve(input logic is_read, input logic [31:0] rd);
    tick();            // ISSUE -> WAIT_START
    busy = 1'b1;
    tick();            // WAIT_START -> WAIT_DONE
    tick();            // still busy in WAIT_DONE
    busy = 1'b0;
    if (is_read) begin
      out_valid = 1'b1;
      data_out  = rd;
    end
    tick();            // completion edge
    out_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [31:0] exp_rdata0);
    check_value({tag, "_ack0"},   {31'd0, c0_ack}, 32'd0);
    check_value({tag, "_ack1"},   {31'd0, c1_ack}, 32'd0);
    check_value({tag, "_inv"},    {31'd0, in_valid}, 32'd0);
    check_value({tag, "_addr"},   {9'd0, addr}, 32'd0);
    check_value({tag, "_rw"},     {31'd0, rw}, 32'd0);
    check_value({tag, "_din"},    data_in, 32'd0);
    check_value({tag, "_rd0"},    c0_rdata, exp_rdata0);
    check_value({tag, "_rd1"},    c1_rdata, 32'd0);
    check_value({tag, "_rv0"},    {31'd0, c0_rvalid}, 32'd0);
    check_value({tag, "_tmo"},    {31'd0, timeout}, 32'd0);
    check_value({tag, "_owner"},  {31'd0, owner}, 32'd0);
  endtask

  initial begin
    int rv0_base;
    int rv1_base;
    logic exp_own;
    logic [31:0] rdv;

    // Reset state
    #12;
    check_idle_outputs("rst", 32'd0);
    tick();
    rst = 1'b1;

    // Single read by c0
    c0_req = 1'b1; c0_rw = 1'b0; c0_addr = 23'h000123;
    tick();
    check_value("rd_ack0", {31'd0, c0_ack}, 32'd1);
    check_value("rd_ack1", {31'd0, c1_ack}, 32'd0);
    check_value("rd_inv",  {31'd0, in_valid}, 32'd1);
    check_value("rd_addr", {9'd0, addr}, 32'h000123);
    check_value("rd_rw",   {31'd0, rw}, 32'd0);
    c0_req = 1'b0;
    serve(1'b1, 32'hDEADBEEF);
    check_value("rd_rv0",  {31'd0, c0_rvalid}, 32'd1);
    check_value("rd_rv1",  {31'd0, c1_rvalid}, 32'd0);
    check_value("rd_data", c0_rdata, 32'hDEADBEEF);
    tick();
    check_value("rd_rv0_pulse", {31'd0, c0_rvalid}, 32'd0);
    check_value("rd_data_hold", c0_rdata, 32'hDEADBEEF);
    check_value("rd_inv_once",  {31'd0, in_valid}, 32'd0);

    // Single write by c1
    rv0_base = rv0_cnt; rv1_base = rv1_cnt;
    c1_req = 1'b1; c1_rw = 1'b1; c1_addr = 23'h7FFFFF; c1_wdata = 32'hA5A5A5A5;
    tick();
    check_value("wr_ack1",  {31'd0, c1_ack}, 32'd1);
    check_value("wr_ack0",  {31'd0, c0_ack}, 32'd0);
    check_value("wr_din",   data_in, 32'hA5A5A5A5);
    check_value("wr_rw",    {31'd0, rw}, 32'd1);
    check_value("wr_addr",  {9'd0, addr}, 32'h007FFFFF);
    check_value("wr_owner", {31'd0, owner}, 32'd1);
    c1_req = 1'b0;
    serve(1'b0, 32'd0);
    tick();
    check_value("wr_no_rv", rv0_cnt + rv1_cnt, rv0_base + rv1_base);
    check_value("wr_hold_din", data_in, 32'hA5A5A5A5);

    // Contention: c1 was served last, so c0 wins first, then strict alternation
    c0_req = 1'b1; c0_rw = 1'b0; c0_addr = 23'h000A00;
    c1_req = 1'b1; c1_rw = 1'b0; c1_addr = 23'h000B00;
    for (int i = 0; i < 6; i++) begin
      exp_own = (i % 2 == 1);
      rdv = 32'h1000_0000 + 32'(i);
      tick();
      check_value($sformatf("ct%0d_ack0", i), {31'd0, c0_ack}, {31'd0, ~exp_own});
      check_value($sformatf("ct%0d_ack1", i), {31'd0, c1_ack}, {31'd0, exp_own});
      check_value($sformatf("ct%0d_owner", i), {31'd0, owner}, {31'd0, exp_own});
      check_value($sformatf("ct%0d_addr", i), {9'd0, addr}, exp_own ? 32'h000B00 : 32'h000A00);
      serve(1'b1, rdv);
      check_value($sformatf("ct%0d_rv", i), {30'd0, c1_rvalid, c0_rvalid}, exp_own ? 32'd2 : 32'd1);
      check_value($sformatf("ct%0d_rdata", i), exp_own ? c1_rdata : c0_rdata, rdv);
    end
    c0_req = 1'b0; c1_req = 1'b0;
    tick();

    // Busy gating in IDLE
    busy = 1'b1;
    c0_req = 1'b1; c0_rw = 1'b0; c0_addr = 23'h000055;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value($sformatf("bg%0d_ack0", i), {31'd0, c0_ack}, 32'd0);
      check_value($sformatf("bg%0d_inv", i),  {31'd0, in_valid}, 32'd0);
    end
    busy = 1'b0;
    tick();
    check_value("bg_ack0", {31'd0, c0_ack}, 32'd1);
    check_value("bg_inv",  {31'd0, in_valid}, 32'd1);
    check_value("bg_addr", {9'd0, addr}, 32'h000055);
    c0_req = 1'b0;
    serve(1'b1, 32'h11111111);
    check_value("bg_rdata", c0_rdata, 32'h11111111);

    // Watchdog: controller never goes busy; 16 cycles in the wait states abort
    c0_req = 1'b1; c0_rw = 1'b0; c0_addr = 23'h000010;
    tick();
    check_value("wd_ack0", {31'd0, c0_ack}, 32'd1);
    c0_req = 1'b0;
    rv0_base = rv0_cnt;
    for (int i = 0; i < 16; i++) tick();
    check_value("wd_before", {31'd0, timeout}, 32'd0);
    tick();
    check_value("wd_fire",  {31'd0, timeout}, 32'd1);
    check_value("wd_no_rv", {31'd0, c0_rvalid}, 32'd0);
    c1_req = 1'b1; c1_rw = 1'b1; c1_addr = 23'h000020; c1_wdata = 32'h0BADF00D;
    tick();
    check_value("wd_ack1",  {31'd0, c1_ack}, 32'd1);
    check_value("wd_din",   data_in, 32'h0BADF00D);
    c1_req = 1'b0;
    serve(1'b0, 32'd0);
    check_value("wd_sticky", {31'd0, timeout}, 32'd1);
    check_value("wd_rvcnt",  rv0_cnt, rv0_base);

    // Reset in the middle of a read
    c0_req = 1'b1; c0_rw = 1'b0; c0_addr = 23'h000200;
    tick();
    c0_req = 1'b0;
    tick();
    busy = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("mrst", 32'd0);
    tick();
    rst = 1'b1;
    busy = 1'b0;
    rv0_base = rv0_cnt; rv1_base = rv1_cnt;
    out_valid = 1'b1; data_out = 32'h00000BAD;
    tick();
    out_valid = 1'b0;
    tick();
    check_value("mrst_late_rv0", rv0_cnt, rv0_base);
    check_value("mrst_late_rv1", rv1_cnt, rv1_base);
    c0_req = 1'b1; c0_addr = 23'h000300;
    tick();
    check_value("mrst_ack0", {31'd0, c0_ack}, 32'd1);
    check_value("mrst_addr", {9'd0, addr}, 32'h000300);
    c0_req = 1'b0;
    serve(1'b1, 32'hCAFEF00D);
    check_value("mrst_rv0",   {31'd0, c0_rvalid}, 32'd1);
    check_value("mrst_rdata", c0_rdata, 32'hCAFEF00D);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
